// File: rtl/usb_pkg.sv
// Shared USB definitions: transmit payload builder states and CRC16 constants.
package usb_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        FINALIZE = 2'd1,
        ARMED    = 2'd2
    } tx_build_state_t;

    localparam logic [15:0] CRC16_POLY_REFL     = 16'hA001;
    localparam logic [15:0] CRC16_INIT          = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL_REFL = 16'hB001;
    localparam int          NUM_WORDS_DEFAULT   = 16;

endpackage

// File: rtl/usb_crc16_word.sv
// Combinational USB CRC16 update over one 32-bit word, byte [7:0] first,
// each byte LSB-first, which reduces to walking bits 0..31 in order.
module usb_crc16_word
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [31:0] word,
    output logic [15:0] crc_out
);

    logic [15:0] crc_w;

    always_comb begin
        crc_w = crc_in;
        for (int i = 0; i < 32; i++) begin
            if (crc_w[0] ^ word[i])
                crc_w = (crc_w >> 1) ^ CRC16_POLY_REFL;
            else
                crc_w = crc_w >> 1;
        end
        crc_out = crc_w;
    end

endmodule

// File: rtl/usb_tx_payload_builder.sv
// Gathers NUM_WORDS words plus an inverted CRC16 into one wide payload and
// holds it with shift_out raised until the ULPI transmitter pulses tx_done.
module usb_tx_payload_builder
    import usb_pkg::*;
#(
    parameter  int NUM_WORDS = NUM_WORDS_DEFAULT,
    localparam int PAYLOAD_W = NUM_WORDS * 32 + 16,
    localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 word_valid,
    input  logic [31:0]          word_data,
    output logic                 word_ready,
    input  logic                 abort,
    input  logic                 tx_done,
    output logic                 shift_out,
    output logic [PAYLOAD_W-1:0] payload,
    output logic [CNT_W-1:0]     word_count
);

    tx_build_state_t        state;
    logic [15:0]            crc;
    logic [15:0]            crc_next;
    logic                   accept;
    logic                   last_word;
    logic [NUM_WORDS-1:0]   word_we;

    assign word_ready = (state == COLLECT);
    // Abort wins over a simultaneous handshake, so the word is never stored.
    assign accept     = word_ready && word_valid && !abort;
    assign last_word  = (word_count == CNT_W'(NUM_WORDS - 1));

    always_comb begin
        word_we = '0;
        for (int k = 0; k < NUM_WORDS; k++)
            word_we[k] = accept && (word_count == CNT_W'(k));
    end

    usb_crc16_word u_crc (
        .crc_in  (crc),
        .word    (word_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            crc        <= CRC16_INIT;
            payload    <= '0;
            word_count <= '0;
            shift_out  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++)
                if (word_we[k]) payload[32*k +: 32] <= word_data;

            case (state)
                COLLECT: begin
                    if (abort) begin
                        payload    <= '0;
                        word_count <= '0;
                        crc        <= CRC16_INIT;
                    end else if (accept) begin
                        crc        <= crc_next;
                        word_count <= word_count + 1'b1;
                        if (last_word) state <= FINALIZE;
                    end
                end
                FINALIZE: begin
                    if (abort) begin
                        payload    <= '0;
                        word_count <= '0;
                        crc        <= CRC16_INIT;
                        state      <= COLLECT;
                    end else begin
                        // Inverted CRC occupies the top 16 bits, low byte sent first.
                        payload[PAYLOAD_W-1 -: 16] <= ~crc;
                        shift_out                  <= 1'b1;
                        state                      <= ARMED;
                    end
                end
                ARMED: begin
                    if (tx_done) begin
                        payload    <= '0;
                        word_count <= '0;
                        crc        <= CRC16_INIT;
                        shift_out  <= 1'b0;
                        state      <= COLLECT;
                    end
                end
                default: begin
                    shift_out <= 1'b0;
                    state     <= COLLECT;
                end
            endcase
        end
    end

endmodule
